// File: rtl/logic32_reg_unit_pkg.sv
// Shared constants for the 32-bit bitwise logic unit and the datapath around it.
package logic32_reg_unit_pkg;

   // Operand and result width; the unit is only built and verified at 32 bits.
   localparam int DATA_WIDTH = 32;

   // Value every result register takes on reset. It is all-zero for the
   // inverting outputs too, so reset is distinguishable from A=B=0.
   localparam logic [DATA_WIDTH-1:0] RESET_VALUE = 32'h0000_0000;

   // Bundle of the four parallel results, handy for anything that muxes them.
   typedef struct packed {
      logic [DATA_WIDTH-1:0] nor_y;
      logic [DATA_WIDTH-1:0] and_y;
      logic [DATA_WIDTH-1:0] inv_a_y;
      logic [DATA_WIDTH-1:0] inv_b_y;
   } logic_results_t;

endpackage : logic32_reg_unit_pkg

// File: rtl/bitwise_gate_array32.sv
// Combinational gate array: per-bit NOR, AND, NOT A and NOT B.
// Each result bit depends only on A[i] and B[i]; there is no cross-bit logic.
module bitwise_gate_array32
   import logic32_reg_unit_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] nor_y,
   output logic [WIDTH-1:0] and_y,
   output logic [WIDTH-1:0] inv_a_y,
   output logic [WIDTH-1:0] inv_b_y
);

   // OR array kept explicit so NOR is literally its inversion.
   logic [WIDTH-1:0] or_y;

   // One gate slice per bit position.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign or_y[gi]    = a[gi] | b[gi];
         assign nor_y[gi]   = ~or_y[gi];
         assign and_y[gi]   = a[gi] & b[gi];
         assign inv_a_y[gi] = ~a[gi];
         assign inv_b_y[gi] = ~b[gi];
      end
   endgenerate

endmodule : bitwise_gate_array32

// File: rtl/logic32_reg_unit.sv
// 32-bit bitwise logic unit: parallel NOR/AND/NOT A/NOT B with a
// load-enabled output register stage and a VALID flag for the ALU result mux.
module logic32_reg_unit
   import logic32_reg_unit_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,      // asynchronous, active-low
   input  logic             EN,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] NOR_Y,
   output logic [WIDTH-1:0] AND_Y,
   output logic [WIDTH-1:0] INV_A_Y,
   output logic [WIDTH-1:0] INV_B_Y,
   output logic             VALID
);

   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

   logic [WIDTH-1:0] nor_c, and_c, inv_a_c, inv_b_c;

   logic [WIDTH-1:0] nor_d, and_d, inv_a_d, inv_b_d;
   logic [WIDTH-1:0] nor_q, and_q, inv_a_q, inv_b_q;
   logic             valid_d, valid_q;

   bitwise_gate_array32 #(
      .WIDTH   (WIDTH)
   ) u_gates (
      .a       (A),
      .b       (B),
      .nor_y   (nor_c),
      .and_y   (and_c),
      .inv_a_y (inv_a_c),
      .inv_b_y (inv_b_c)
   );

   // Next-state: load all four results when enabled, otherwise hold; VALID follows EN.
   always_comb begin
      nor_d   = nor_q;
      and_d   = and_q;
      inv_a_d = inv_a_q;
      inv_b_d = inv_b_q;
      valid_d = EN;
      if (EN) begin
         nor_d   = nor_c;
         and_d   = and_c;
         inv_a_d = inv_a_c;
         inv_b_d = inv_b_c;
      end
   end

   // Result registers; reset clears everything immediately, independent of CLK.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         nor_q   <= RST_VAL;
         and_q   <= RST_VAL;
         inv_a_q <= RST_VAL;
         inv_b_q <= RST_VAL;
         valid_q <= 1'b0;
      end else begin
         nor_q   <= nor_d;
         and_q   <= and_d;
         inv_a_q <= inv_a_d;
         inv_b_q <= inv_b_d;
         valid_q <= valid_d;
      end
   end

   assign NOR_Y   = nor_q;
   assign AND_Y   = and_q;
   assign INV_A_Y = inv_a_q;
   assign INV_B_Y = inv_b_q;
   assign VALID   = valid_q;

endmodule : logic32_reg_unit

// File: tb/tb_logic32_reg_unit.sv
// Testbench for logic32_reg_unit: directed table, hold/reset sequences and
// randomized traffic checked against a register-level reference model.
module tb_logic32_reg_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        EN;
   logic [31:0] A, B;
   logic [31:0] NOR_Y, AND_Y, INV_A_Y, INV_B_Y;
   logic        VALID;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model state: what the four outputs and VALID should show.
   logic [31:0] m_nor, m_and, m_ia, m_ib;
   logic        m_valid;

   typedef struct {
      logic [31:0] a, b;
      logic [31:0] e_nor, e_and, e_ia, e_ib;
   } vec_t;

   vec_t vecs [6];

   logic32_reg_unit dut (
      .CLK     (CLK),
      .RST     (RST),
      .EN      (EN),
      .A       (A),
      .B       (B),
      .NOR_Y   (NOR_Y),
      .AND_Y   (AND_Y),
      .INV_A_Y (INV_A_Y),
      .INV_B_Y (INV_B_Y),
      .VALID   (VALID)
   );

   always #5 CLK = ~CLK;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] e_nor, input logic [31:0] e_and,
                          input logic [31:0] e_ia, input logic [31:0] e_ib, input logic e_v);
      chk32({tag, ".NOR_Y"}, NOR_Y, e_nor);
      chk32({tag, ".AND_Y"}, AND_Y, e_and);
      chk32({tag, ".INV_A_Y"}, INV_A_Y, e_ia);
      chk32({tag, ".INV_B_Y"}, INV_B_Y, e_ib);
      chk32({tag, ".VALID"}, {31'b0, VALID}, {31'b0, e_v});
      $display("%s: A=%08h B=%08h EN=%0b -> NOR=%08h AND=%08h IA=%08h IB=%08h V=%0b",
               tag, A, B, EN, NOR_Y, AND_Y, INV_A_Y, INV_B_Y, VALID);
   endtask

   // Model of one rising edge with RST high: enabled edges capture the
   // specified bitwise results, disabled edges hold and drop VALID.
   task automatic model_edge(input logic en, input logic [31:0] a, input logic [31:0] b);
      if (en) begin
         m_nor = ~(a | b);
         m_and = a & b;
         m_ia  = ~a;
         m_ib  = ~b;
      end
      m_valid = en;
   endtask

   task automatic model_reset();
      m_nor = 0; m_and = 0; m_ia = 0; m_ib = 0; m_valid = 0;
   endtask

   // Inputs are driven just after a falling edge; one rising edge; check at the next falling edge.
   task automatic cycle(input string tag, input logic en, input logic [31:0] a, input logic [31:0] b);
      EN = en; A = a; B = b;
      @(posedge CLK);
      model_edge(en, a, b);
      @(negedge CLK);
      chk_all(tag, m_nor, m_and, m_ia, m_ib, m_valid);
   endtask

   initial begin
      vecs[0] = '{32'h0a17b980, 32'h11af6077, 32'he4400608, 32'h00072000, 32'hf5e8467f, 32'hee509f88};
      vecs[1] = '{32'h34cdd610, 32'h7b5aaee1, 32'h8020010e, 32'h30488600, 32'hcb3229ef, 32'h84a5511e};
      vecs[2] = '{32'h0134ba87, 32'h00000000, 32'hfecb4578, 32'h00000000, 32'hfecb4578, 32'hffffffff};
      vecs[3] = '{32'h00000000, 32'hf987bae1, 32'h0678451e, 32'h00000000, 32'hffffffff, 32'h0678451e};
      vecs[4] = '{32'hffffffff, 32'hffffffff, 32'h00000000, 32'hffffffff, 32'h00000000, 32'h00000000};
      vecs[5] = '{32'haaaaaaaa, 32'h55555555, 32'h00000000, 32'h00000000, 32'h55555555, 32'haaaaaaaa};

      // Reset held low with EN=1 and live operands: outputs must stay cleared.
      RST = 1'b0; EN = 1'b1; A = 32'hffffffff; B = 32'h0;
      model_reset();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk_all("reset_hold", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

      // Release reset; the first enabled edge performs the first capture.
      RST = 1'b1;
      cycle("first_cap", 1'b1, 32'hffffffff, 32'h0);
      chk32("first_cap.INV_B_lit", INV_B_Y, 32'hffffffff);

      // Directed table, back-to-back enabled edges (one result per cycle).
      for (int i = 0; i < 6; i++) begin
         EN = 1'b1; A = vecs[i].a; B = vecs[i].b;
         @(posedge CLK);
         model_edge(1'b1, vecs[i].a, vecs[i].b);
         @(negedge CLK);
         chk_all($sformatf("table%0d", i), vecs[i].e_nor, vecs[i].e_and, vecs[i].e_ia, vecs[i].e_ib, 1'b1);
      end

      // Hold: capture a known set, then three disabled edges with zeroed operands.
      cycle("hold_cap", 1'b1, vecs[0].a, vecs[0].b);
      for (int i = 0; i < 3; i++)
         cycle($sformatf("hold%0d", i), 1'b0, 32'h0, 32'h0);
      chk32("hold_unchanged", NOR_Y, 32'he4400608);
      cycle("hold_release", 1'b1, 32'h0, 32'h0);
      chk32("hold_release.NOR_lit", NOR_Y, 32'hffffffff);

      // Randomized traffic, including operand changes between edges that
      // must not disturb the registered outputs.
      for (int i = 0; i < 200; i++) begin
         logic        en;
         logic [31:0] a, b;
         en = 1'($urandom_range(0, 3) != 0);
         a  = $urandom;
         b  = (i % 16 == 0) ? a : $urandom;
         EN = en; A = a; B = b;
         @(posedge CLK);
         model_edge(en, a, b);
         #1;
         A = $urandom; B = $urandom;
         @(negedge CLK);
         chk32($sformatf("rnd%0d.NOR_Y", i), NOR_Y, m_nor);
         chk32($sformatf("rnd%0d.AND_Y", i), AND_Y, m_and);
         chk32($sformatf("rnd%0d.INV_A_Y", i), INV_A_Y, m_ia);
         chk32($sformatf("rnd%0d.INV_B_Y", i), INV_B_Y, m_ib);
         chk32($sformatf("rnd%0d.VALID", i), {31'b0, VALID}, {31'b0, m_valid});
         $display("rnd%0d: en=%0b a=%08h b=%08h -> NOR=%08h AND=%08h IA=%08h IB=%08h V=%0b",
                  i, en, a, b, NOR_Y, AND_Y, INV_A_Y, INV_B_Y, VALID);
      end

      // Asynchronous reset between edges: outputs clear before the next rising edge.
      cycle("async_pre", 1'b1, vecs[1].a, vecs[1].b);
      #2;
      RST = 1'b0;
      model_reset();
      #1;
      chk_all("async_clear", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      EN = 1'b1; A = vecs[1].a; B = vecs[1].b;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk_all("async_hold", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

      // Release with EN low: nothing stale may load; then the first enabled edge captures.
      RST = 1'b1;
      cycle("rel_noen", 1'b0, vecs[1].a, vecs[1].b);
      cycle("rel_cap", 1'b1, vecs[3].a, vecs[3].b);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_logic32_reg_unit

// File: doc/logic32_reg_unit.md
Name: logic32_reg_unit

Overview:
- 32-bit bitwise logic unit for the CS147 datapath.
- Computes NOR(A,B), AND(A,B), NOT(A) and NOT(B) in parallel from gate-level 32-bit arrays.
- Captures all four results in an output register stage with a load enable.
- Feeds the ALU result mux; each result is a single-cycle registered value.

Parameters:
- WIDTH, 32, operand and result width in bits; only 32 is supported and verified.

Ports:
- CLK  input  1  system clock; rising-edge active.
- RST  input  1  asynchronous, active-low reset.
- EN  input  1  load enable; results are captured on a rising CLK edge when EN=1.
- A  input  32  operand A.
- B  input  32  operand B.
- NOR_Y  output  32  registered ~(A|B).
- AND_Y  output  32  registered A&B.
- INV_A_Y  output  32  registered ~A.
- INV_B_Y  output  32  registered ~B.
- VALID  output  1  registered copy of EN; high for the cycle whose outputs reflect a fresh capture.

Behaviour:
- Combinational core:
  - Purely bitwise, bit i of each result depends only on A[i] and B[i].
  - No carries and no cross-bit interaction.
  - NOR is formed as the inversion of the OR array, not via a separate reduction.
- Register stage:
  - On RST falling (asynchronous), NOR_Y, AND_Y, INV_A_Y, INV_B_Y = 32'h00000000 and VALID = 0, regardless of CLK.
  - Reset values are all-zero even for the inverting outputs; reset state is not the logical result of A=B=0.
  - While RST=0, outputs hold reset values and EN is ignored.
- Rising CLK edge with RST=1:
  - EN=1: all four result registers load the current combinational results; VALID <= 1.
  - EN=0: result registers hold; VALID <= 0.
- Latency: exactly 1 cycle from A/B/EN sampled at an edge to outputs updated after that edge.
- A/B changes between edges have no effect on outputs until the next enabled edge.
- Reset released mid-operation: first capture occurs on the first rising edge with RST=1 and EN=1; no partial or stale load.
- Continuous EN=1: throughput of one result set per cycle.
- No X propagation requirement beyond standard RTL; outputs are never X after reset.

Decomposition:
- Shared package/header holds:
  - WIDTH constant (32).
  - Reset value constant (32'h0).
  - The project's definition include, shared with the rest of the datapath.
- Sub-modules:
  - bitwise_gate_array32: combinational, outputs all four results from A and B; instantiated once.
  - Register stage is inline in the top module.

Test Plan:
- Reset: RST=0 with A=32'hffffffff, B=0, EN=1, toggling CLK -> all results 0, VALID=0. Release RST, one enabled edge -> NOR_Y=0, AND_Y=0, INV_A_Y=0, INV_B_Y=32'hffffffff, VALID=1.
- A=32'h0a17b980, B=32'h11af6077, EN=1, one edge -> NOR_Y=32'he4400608, AND_Y=32'h00072000, INV_A_Y=32'hf5e8467f, INV_B_Y=32'hee509f88.
- A=32'h34cdd610, B=32'h7b5aaee1, EN=1 -> NOR_Y=32'h8020010e, AND_Y=32'h30488600, INV_A_Y=32'hcb3229ef, INV_B_Y=32'h84a5511e.
- A=32'h0134ba87, B=0, EN=1 -> NOR_Y=INV_A_Y=32'hfecb4578, AND_Y=0, INV_B_Y=32'hffffffff. Then A=0, B=32'hf987bae1 -> NOR_Y=INV_B_Y=32'h0678451e, AND_Y=0, INV_A_Y=32'hffffffff.
- Hold: after a capture, set EN=0 and change A=B=0 for 3 edges -> outputs unchanged, VALID=0. EN=1 -> NOR_Y=32'hffffffff, AND_Y=0, INV_A_Y=INV_B_Y=32'hffffffff.
- Async reset mid-cycle: assert RST low between edges while outputs are nonzero -> outputs clear immediately, before the next CLK edge.
